// File: rtl/trap_handler_ctrl.sv
// trap_handler_ctrl
//   Exception entry/return controller on the consumer side of the trap-decode
//   interface. SYSCALL/BREAK requests latch EPC, Cause.ExcCode and Status.EXL,
//   then the pipeline is flushed for one cycle and fetch is redirected to
//   HANDLER_VEC for one cycle. ERET follows the same flush/redirect sequence
//   but targets EPC and clears EXL. A CP0 port serves MFC0/MTC0.
//
//   Optional feature macro: TRAP_COUNT_EN adds a 32-bit TrapCount register at
//   CP0 address 9 that counts accepted traps.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous reset, active-high
//   trap_req       decode reports a trap instruction this cycle
//   trap_type[5:0] trap code (8=SYSCALL, 9=BREAK, 0=none)
//   trap_pc[31:0]  PC of the trapping instruction
//   eret           decode reports an ERET instruction
//   cp0_we         MTC0 write strobe
//   cp0_addr[4:0]  CP0 register number (12=Status, 13=Cause, 14=EPC)
//   cp0_wdata      MTC0 data
//   cp0_rdata      MFC0 data, combinational from cp0_addr
//   flush          kill younger in-flight instructions
//   redirect_valid fetch must load redirect_pc
//   redirect_pc    redirect target
//   busy           stall decode
//   exl            Status.EXL

module trap_handler_ctrl #(
   parameter logic [31:0] HANDLER_VEC = 32'h0000_0080,
   parameter logic [31:0] EPC_RST     = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trap_req,
   input  logic [5:0]  trap_type,
   input  logic [31:0] trap_pc,
   input  logic        eret,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy,
   output logic        exl
);

   localparam logic [4:0] AddrCount  = 5'd9;
   localparam logic [4:0] AddrStatus = 5'd12;
   localparam logic [4:0] AddrCause  = 5'd13;
   localparam logic [4:0] AddrEpc    = 5'd14;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFlush = 2'd1,
      StRedir = 2'd2
   } state_e;

   // kind of the sequence in flight: trap entry or ERET return
   typedef enum logic {
      KindTrap = 1'b0,
      KindRet  = 1'b1
   } kind_e;

   state_e      state_q, state_d;
   kind_e       kind_q, kind_d;
   logic [31:0] epc_q, epc_d;
   logic [1:0]  status_q, status_d;  // bit0=IE, bit1=EXL
   logic [4:0]  cause_q, cause_d;    // Cause[6:2]
`ifdef TRAP_COUNT_EN
   logic [31:0] trap_cnt_q, trap_cnt_d;
`endif

   logic trap_accept;

   assign trap_accept = trap_req && (trap_type != 6'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         kind_q     <= KindTrap;
         epc_q      <= EPC_RST;
         status_q   <= 2'b00;
         cause_q    <= 5'd0;
`ifdef TRAP_COUNT_EN
         trap_cnt_q <= 32'd0;
`endif
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         epc_q      <= epc_d;
         status_q   <= status_d;
         cause_q    <= cause_d;
`ifdef TRAP_COUNT_EN
         trap_cnt_q <= trap_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      epc_d      = epc_q;
      status_d   = status_q;
      cause_d    = cause_q;
`ifdef TRAP_COUNT_EN
      trap_cnt_d = trap_cnt_q;
`endif

      // Software writes first; hardware updates below override them.
      if (cp0_we) begin
         case (cp0_addr)
            AddrStatus: status_d = cp0_wdata[1:0];
            AddrEpc:    epc_d    = cp0_wdata;
`ifdef TRAP_COUNT_EN
            AddrCount:  trap_cnt_d = cp0_wdata;
`endif
            default: ;
         endcase
      end

      unique case (state_q)
         StIdle: begin
            if (trap_accept) begin
               // nested trap keeps the original return address
               if (!status_q[1]) epc_d = trap_pc;
               cause_d     = trap_type[4:0];
               status_d[1] = 1'b1;
               kind_d      = KindTrap;
               state_d     = StFlush;
`ifdef TRAP_COUNT_EN
               trap_cnt_d  = trap_cnt_q + 32'd1;
`endif
            end else if (eret) begin
               kind_d  = KindRet;
               state_d = StFlush;
            end
         end
         StFlush: state_d = StRedir;
         StRedir: begin
            if (kind_q == KindRet) status_d[1] = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      flush          = (state_q == StFlush);
      redirect_valid = (state_q == StRedir);
      busy           = (state_q != StIdle);
      exl            = status_q[1];
      redirect_pc    = 32'd0;
      if (state_q == StRedir) begin
         redirect_pc = (kind_q == KindRet) ? epc_q : HANDLER_VEC;
      end
   end

   always_comb begin
      cp0_rdata = 32'd0;
      case (cp0_addr)
         AddrStatus: cp0_rdata = {30'd0, status_q};
         AddrCause:  cp0_rdata = {25'd0, cause_q, 2'b00};
         AddrEpc:    cp0_rdata = epc_q;
`ifdef TRAP_COUNT_EN
         AddrCount:  cp0_rdata = trap_cnt_q;
`endif
         default:    cp0_rdata = 32'd0;
      endcase
   end

endmodule

// File: doc/trap_handler_ctrl.md
Name: trap_handler_ctrl

Overview:
Consumer side of the trap-decode interface. It accepts SYSCALL/BREAK trap requests (trap_type 8/9) from the decode stage and performs exception entry: it latches EPC, Cause.ExcCode and Status.EXL, flushes the pipeline and redirects fetch to the handler vector. It also implements ERET return, and gives decode a CP0 register port for MFC0/MTC0.

Parameters:
HANDLER_VEC, 32'h0000_0080, fetch address for exception entry
EPC_RST, 32'h0000_0000, reset value of EPC

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
trap_req  in  1  decode reports a trap instruction this cycle
trap_type  in  6  trap code from decode; 8=SYSCALL, 9=BREAK, 0=none
trap_pc  in  32  PC of the trapping instruction
eret  in  1  decode reports an ERET instruction
cp0_we  in  1  MTC0 write strobe
cp0_addr  in  5  CP0 register number: 12=Status, 13=Cause, 14=EPC
cp0_wdata  in  32  MTC0 data
cp0_rdata  out  32  MFC0 data, combinational from cp0_addr
flush  out  1  kill younger in-flight instructions
redirect_valid  out  1  fetch must load redirect_pc
redirect_pc  out  32  target PC
busy  out  1  stall decode; no new requests are accepted
exl  out  1  Status.EXL

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, EPC=EPC_RST, Status=0, Cause=0. Outputs: flush=0, redirect_valid=0, redirect_pc=0, busy=0, exl=0.
- FSM states: IDLE, FLUSH, REDIR. Encoding is free.
- IDLE, trap_req=1 and trap_type!=0:
  - If EXL=0, EPC<=trap_pc.
  - If EXL=1, EPC is kept (nested trap).
  - Cause[6:2]<=trap_type[4:0]; Status[1] (EXL)<=1; latch kind=TRAP.
  - Next state FLUSH.
- IDLE, trap_req=1 with trap_type=0: ignored.
- IDLE, eret=1 (no valid trap): latch kind=RET, next state FLUSH.
- trap_req and eret in the same cycle: the trap wins and eret is dropped.
- FLUSH (one cycle): flush=1, busy=1, next state REDIR.
- REDIR (one cycle): redirect_valid=1, busy=1, next state IDLE.
  - kind=TRAP: redirect_pc=HANDLER_VEC.
  - kind=RET: redirect_pc=EPC, and EXL<=0 at the end of this cycle.
- Latency: request at edge N, flush high in cycle N+1, redirect high in cycle N+2, IDLE again at N+3.
- trap_req/eret arriving while state!=IDLE: ignored, because upstream must honour busy.
- Registers are 32 bits. Unused Cause/Status bits read 0. Unmapped cp0_addr reads 0.
- Software writes (cp0_we=1, state IDLE or not):
  - addr 12 writes Status[1:0] (bit0=IE, bit1=EXL).
  - addr 14 writes EPC.
  - addr 13 is read-only; the write is ignored.
- Write collision: if a hardware update to the same register happens at the same edge, the hardware value wins.
- cp0_rdata shows register contents before the current edge. There is no bypass.
- exl = Status[1] at all times.
- Reset asserted mid-sequence: the FSM returns to IDLE at that edge. Any pending redirect is abandoned, and all registers take their reset values.

Optional Feature:
TRAP_COUNT_EN
- Defined: adds a 32-bit TrapCount register at CP0 address 9.
  - Increments once per accepted trap, on the IDLE->FLUSH edge. It does not increment on ERET or on ignored requests.
  - Wraps 0xFFFF_FFFF->0.
  - Readable via cp0_rdata; writable via MTC0 addr 9. Increment beats the write in a collision.
  - Reset value 0.
- Undefined: no counter exists and address 9 reads 0.

Test Plan:
1. Reset, then trap_req=1, trap_type=8, trap_pc=0x0000_0040 -> next cycle flush=1, busy=1. Following cycle redirect_valid=1, redirect_pc=0x80. Then EPC=0x40, Cause=0x20, exl=1.
2. After scenario 1, trap_type=9 at trap_pc=0x84 with EXL=1 -> EPC stays 0x40, Cause=0x24, redirect to 0x80.
3. MTC0 addr 14 data 0x44, then eret=1 -> flush one cycle, then redirect_pc=0x44, exl drops to 0 after the REDIR cycle, busy=0 at N+3.
4. trap_req=1 (type 8) and eret=1 in the same cycle with EXL=0 -> trap path taken (redirect 0x80, exl=1). A second trap_req during FLUSH is ignored: EPC/Cause unchanged, exactly one redirect.
5. rst asserted in the FLUSH cycle -> next cycle redirect_valid=0, flush=0, busy=0, EPC=0, exl=0. MTC0 addr 13 data 0xFFFF_FFFF -> Cause still reads 0.
6. With TRAP_COUNT_EN: three traps plus one ERET -> addr 9 reads 3. Preload 0xFFFF_FFFF and take one trap -> reads 0. Without the macro, addr 9 reads 0.
